dm_arb: RTL

DM_ARB -- requirements
Module: dm_arb

---
 rtl/dm_arb_pkg.sv | 16 +
 rtl/dm_arb_if.sv | 27 ++
 rtl/dm_arb_lock_timer.sv | 38 +++
 rtl/dm_arb.sv | 100 ++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared owner-state encoding and lock counter width for dm_arb
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } dm_arb_state_e;

    localparam int LOCK_CNT_W = 8;

    function automatic dm_arb_state_e own_state(input logic master1);
        return master1 ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/dm_arb_if.sv
// rtl/dm_arb_if.sv - two-master request/grant bus plus data memory port
interface dm_arb_if;
    logic        m0_req,   m1_req;
    logic        m0_we,    m1_we;
    logic [11:2] m0_addr,  m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_lock,  m1_lock;
    logic        m0_gnt,   m1_gnt;
    logic [31:0] rdata;
    logic [11:2] dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [31:0] dm_dout;

    // master side also hosts the data memory, so it supplies dm_dout
    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_lock, m1_lock, dm_dout,
        input  m0_gnt, m1_gnt, rdata, dm_addr, dm_din, dm_we
    );

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_lock, m1_lock, dm_dout,
        output m0_gnt, m1_gnt, rdata, dm_addr, dm_din, dm_we
    );
endinterface

// File: rtl/dm_arb_lock_timer.sv
// rtl/dm_arb_lock_timer.sv - consecutive contested locked-grant counter with saturation and timeout
module dm_arb_lock_timer
    import dm_arb_pkg::*;
#(
    parameter int LOCK_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic expired_o
);
    localparam logic [LOCK_CNT_W-1:0] MAX_C = LOCK_CNT_W'(LOCK_MAX);

    logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;
    logic [LOCK_CNT_W:0]   run_incl;

    // Timeout includes the grant of the current cycle so the owner gets exactly LOCK_MAX
    assign run_incl  = {1'b0, cnt_q} + {{LOCK_CNT_W{1'b0}}, inc_i};
    assign expired_o = (run_incl >= {1'b0, MAX_C});

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/dm_arb.sv
// rtl/dm_arb.sv - two-master data memory arbiter, round-robin with optional lock (DM_ARB_LOCK_EN)
module dm_arb
    import dm_arb_pkg::*;
#(
    parameter int LOCK_MAX = 15
) (
    input  logic    clk,
    input  logic    rst_n,
    dm_arb_if.slave bus
);
    dm_arb_state_e state_q, state_d;
    logic          rr_q, rr_d;
    logic          own0, own1;
    logic          gnt0, gnt1;
    logic          own_req, own_lock, other_req;
    logic          lock_hold;

    assign own0      = (state_q == OWN0);
    assign own1      = (state_q == OWN1);
    assign gnt0      = own0 & bus.m0_req;
    assign gnt1      = own1 & bus.m1_req;
    assign own_req   = gnt0 | gnt1;
    assign own_lock  = (own0 & bus.m0_lock) | (own1 & bus.m1_lock);
    assign other_req = (own0 & bus.m1_req) | (own1 & bus.m0_req);

    assign bus.m0_gnt  = gnt0;
    assign bus.m1_gnt  = gnt1;
    assign bus.dm_addr = own0 ? bus.m0_addr  : (own1 ? bus.m1_addr  : '0);
    assign bus.dm_din  = own0 ? bus.m0_wdata : (own1 ? bus.m1_wdata : '0);
    assign bus.dm_we   = (gnt0 & bus.m0_we) | (gnt1 & bus.m1_we);
    // Gated so the bus reads 0 whenever nobody is being served
    assign bus.rdata   = own_req ? bus.dm_dout : '0;

`ifdef DM_ARB_LOCK_EN
    logic lock_inc, lock_clr, lock_expired;

    assign lock_inc  = own_req & own_lock & other_req;
    assign lock_clr  = (state_d != state_q) | ~own_lock;
    assign lock_hold = own_req & own_lock & ~lock_expired;

    dm_arb_lock_timer #(
        .LOCK_MAX (LOCK_MAX)
    ) u_lock_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (lock_inc),
        .clr_i     (lock_clr),
        .expired_o (lock_expired)
    );
`else
    logic                  unused_lock;
    logic [LOCK_CNT_W-1:0] unused_lock_max;

    assign unused_lock     = own_lock;
    assign unused_lock_max = LOCK_CNT_W'(LOCK_MAX);
    assign lock_hold       = 1'b0;
`endif

    // rr = 1 means m1 is preferred at the next contested pick from IDLE
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        if (gnt0) begin
            rr_d = 1'b1;
        end else if (gnt1) begin
            rr_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (bus.m0_req && bus.m1_req) begin
                    state_d = own_state(rr_q);
                end else if (bus.m0_req) begin
                    state_d = OWN0;
                end else if (bus.m1_req) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (lock_hold) begin
                    state_d = state_q;
                end else if (other_req) begin
                    state_d = own_state(own0);
                end else if (!own_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end
endmodule
